mem_arbiter: RTL and testbench

- Two-master, one-slave memory arbiter for the multi-cycle RV32E core.
- Master 0 is the IFU instruction fetch. It is read-only, so its write inputs are tied 0 by the integrator.
- Master 1 is the LSU load/store.
- Both share one SRAM-style slave port (req/resp valid-ready channels).
- One outstanding transaction at a time. A response watchdog returns an error response if the slave stalls.

---
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IFU/LSU masters, the arbiter and the shared SRAM-style slave.
// The arbiter uses the slave modport; the CPU-side masters and the memory use the master modport.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            m0_req_valid;
  logic            m0_req_ready;
  logic [AW-1:0]   m0_addr;
  logic            m0_resp_valid;
  logic            m0_resp_ready;
  logic [DW-1:0]   m0_rdata;
  logic            m0_err;

  logic            m1_req_valid;
  logic            m1_req_ready;
  logic [AW-1:0]   m1_addr;
  logic            m1_wen;
  logic [DW-1:0]   m1_wdata;
  logic [DW/8-1:0] m1_wmask;
  logic            m1_resp_valid;
  logic            m1_resp_ready;
  logic [DW-1:0]   m1_rdata;
  logic            m1_err;

  logic            s_req_valid;
  logic            s_req_ready;
  logic [AW-1:0]   s_addr;
  logic            s_wen;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wmask;
  logic            s_resp_valid;
  logic            s_resp_ready;
  logic [DW-1:0]   s_rdata;

  modport slave (
    input  m0_req_valid, m0_addr, m0_resp_ready,
    input  m1_req_valid, m1_addr, m1_wen, m1_wdata, m1_wmask, m1_resp_ready,
    input  s_req_ready, s_resp_valid, s_rdata,
    output m0_req_ready, m0_resp_valid, m0_rdata, m0_err,
    output m1_req_ready, m1_resp_valid, m1_rdata, m1_err,
    output s_req_valid, s_addr, s_wen, s_wdata, s_wmask, s_resp_ready
  );

  modport master (
    output m0_req_valid, m0_addr, m0_resp_ready,
    output m1_req_valid, m1_addr, m1_wen, m1_wdata, m1_wmask, m1_resp_ready,
    output s_req_ready, s_resp_valid, s_rdata,
    input  m0_req_ready, m0_resp_valid, m0_rdata, m0_err,
    input  m1_req_ready, m1_resp_valid, m1_rdata, m1_err,
    input  s_req_valid, s_addr, s_wen, s_wdata, s_wmask, s_resp_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter, fixed LSU priority,
// one outstanding transaction, with a response watchdog forcing an error reply.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT, RESP, DONE} state_t;

  state_t          state, state_n;
  logic            owner;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   addr_q;
  logic            wen_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wmask_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;

  logic grant_m0, grant_m1, resp_ok, resp_to;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      cnt     <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (grant_m1) begin
        owner   <= 1'b1;
        addr_q  <= bus.m1_addr;
        wen_q   <= bus.m1_wen;
        wdata_q <= bus.m1_wdata;
        wmask_q <= bus.m1_wmask;
      end else if (grant_m0) begin
        owner   <= 1'b0;
        addr_q  <= bus.m0_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= '0;
      end
      // Counter only runs while staying in RESP, so it is zero on every RESP entry.
      if (state == RESP && state_n == RESP) cnt <= cnt + 1'b1;
      else                                  cnt <= '0;
      if (resp_ok) begin
        rdata_q <= bus.s_rdata;
        err_q   <= 1'b0;
      end else if (resp_to) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    grant_m0 = 1'b0;
    grant_m1 = 1'b0;
    resp_ok  = 1'b0;
    resp_to  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.m1_req_valid) begin
          grant_m1 = 1'b1;
          state_n  = GRANT;
        end else if (bus.m0_req_valid) begin
          grant_m0 = 1'b1;
          state_n  = GRANT;
        end
      end
      GRANT: if (bus.s_req_ready) state_n = RESP;
      RESP: begin
        if (bus.s_resp_valid) begin
          resp_ok = 1'b1;
          state_n = DONE;
        end else if (cnt == CNT_LAST) begin
          resp_to = 1'b1;
          state_n = DONE;
        end
      end
      DONE: if (owner ? bus.m1_resp_ready : bus.m0_resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.m0_req_ready  = grant_m0;
    bus.m1_req_ready  = grant_m1;
    bus.m0_resp_valid = (state == DONE) && !owner;
    bus.m1_resp_valid = (state == DONE) && owner;
    bus.m0_rdata      = rdata_q;
    bus.m1_rdata      = rdata_q;
    bus.m0_err        = err_q;
    bus.m1_err        = err_q;
    bus.s_req_valid   = (state == GRANT);
    bus.s_addr        = addr_q;
    bus.s_wen         = wen_q;
    bus.s_wdata       = wdata_q;
    bus.s_wmask       = wmask_q;
    bus.s_resp_ready  = (state == RESP);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, outputs are
// checked 1 ns later, each vector's expected values written out by hand.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance to the next falling edge; caller then sets inputs and calls settle().
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    bus.m0_req_valid  = 1'b0;
    bus.m0_addr       = '0;
    bus.m0_resp_ready = 1'b0;
    bus.m1_req_valid  = 1'b0;
    bus.m1_addr       = '0;
    bus.m1_wen        = 1'b0;
    bus.m1_wdata      = '0;
    bus.m1_wmask      = '0;
    bus.m1_resp_ready = 1'b0;
    bus.s_req_ready   = 1'b0;
    bus.s_resp_valid  = 1'b0;
    bus.s_rdata       = '0;

    // Reset state
    step(); step();
    rst = 1'b0;
    settle();
    check("rst_s_req_valid",  64'(bus.s_req_valid), 0);
    check("rst_s_resp_ready", 64'(bus.s_resp_ready), 0);
    check("rst_m0_resp_valid", 64'(bus.m0_resp_valid), 0);
    check("rst_m1_resp_valid", 64'(bus.m1_resp_valid), 0);
    check("rst_m0_req_ready", 64'(bus.m0_req_ready), 0);
    check("rst_s_addr",       64'(bus.s_addr), 0);
    check("rst_m0_rdata",     64'(bus.m0_rdata), 0);

    // Single m0 fetch, minimum latency
    step();
    bus.m0_req_valid = 1'b1;
    bus.m0_addr      = 32'h8000_0000;
    settle();
    check("t1_c0_m0_req_ready", 64'(bus.m0_req_ready), 1);
    check("t1_c0_m1_req_ready", 64'(bus.m1_req_ready), 0);
    check("t1_c0_s_req_valid",  64'(bus.s_req_valid), 0);
    step();
    bus.m0_req_valid = 1'b0;
    bus.s_req_ready  = 1'b1;
    settle();
    check("t1_c1_s_req_valid", 64'(bus.s_req_valid), 1);
    check("t1_c1_s_addr",      64'(bus.s_addr), 64'h8000_0000);
    check("t1_c1_s_wen",       64'(bus.s_wen), 0);
    check("t1_c1_m1_resp_valid", 64'(bus.m1_resp_valid), 0);
    step();
    bus.s_req_ready  = 1'b0;
    bus.s_resp_valid = 1'b1;
    bus.s_rdata      = 32'h0000_0413;
    settle();
    check("t1_c2_s_resp_ready",  64'(bus.s_resp_ready), 1);
    check("t1_c2_m0_resp_valid", 64'(bus.m0_resp_valid), 0);
    step();
    bus.s_resp_valid  = 1'b0;
    bus.s_rdata       = '0;
    bus.m0_resp_ready = 1'b1;
    settle();
    check("t1_c3_m0_resp_valid", 64'(bus.m0_resp_valid), 1);
    check("t1_c3_m0_rdata",      64'(bus.m0_rdata), 64'h0000_0413);
    check("t1_c3_m0_err",        64'(bus.m0_err), 0);
    check("t1_c3_m1_resp_valid", 64'(bus.m1_resp_valid), 0);
    step();
    bus.m0_resp_ready = 1'b0;
    settle();
    check("t1_c4_m0_resp_valid", 64'(bus.m0_resp_valid), 0);
    check("t1_c4_s_req_valid",   64'(bus.s_req_valid), 0);

    // Simultaneous requests: LSU write wins
    step();
    bus.m0_req_valid = 1'b1;
    bus.m0_addr      = 32'h8000_0004;
    bus.m1_req_valid = 1'b1;
    bus.m1_addr      = 32'h8000_1000;
    bus.m1_wen       = 1'b1;
    bus.m1_wdata     = 32'hDEAD_BEEF;
    bus.m1_wmask     = 4'hF;
    settle();
    check("t2_m1_req_ready", 64'(bus.m1_req_ready), 1);
    check("t2_m0_req_ready", 64'(bus.m0_req_ready), 0);
    step();
    bus.m1_req_valid = 1'b0;
    bus.m1_wen       = 1'b0;
    bus.m1_wdata     = '0;
    bus.m1_wmask     = '0;
    bus.s_req_ready  = 1'b1;
    settle();
    check("t2_s_req_valid", 64'(bus.s_req_valid), 1);
    check("t2_s_addr",      64'(bus.s_addr), 64'h8000_1000);
    check("t2_s_wen",       64'(bus.s_wen), 1);
    check("t2_s_wmask",     64'(bus.s_wmask), 64'hF);
    check("t2_s_wdata",     64'(bus.s_wdata), 64'hDEAD_BEEF);
    check("t2_grant_m0_req_ready", 64'(bus.m0_req_ready), 0);
    step();
    bus.s_req_ready  = 1'b0;
    bus.s_resp_valid = 1'b1;
    settle();
    check("t2_s_resp_ready", 64'(bus.s_resp_ready), 1);
    step();
    bus.s_resp_valid  = 1'b0;
    bus.m1_resp_ready = 1'b1;
    settle();
    check("t2_m1_resp_valid", 64'(bus.m1_resp_valid), 1);
    check("t2_m0_resp_valid", 64'(bus.m0_resp_valid), 0);
    check("t2_done_m0_req_ready", 64'(bus.m0_req_ready), 0);
    step();
    bus.m1_resp_ready = 1'b0;
    settle();
    check("t2_idle_m0_req_ready", 64'(bus.m0_req_ready), 1);

    // Slave stalls the request for 5 cycles
    step();
    bus.m0_req_valid = 1'b0;
    settle();
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_s_req_valid",  64'(bus.s_req_valid), 1);
      check("t3_stall_s_addr",       64'(bus.s_addr), 64'h8000_0004);
      check("t3_stall_s_wen",        64'(bus.s_wen), 0);
      check("t3_stall_s_resp_ready", 64'(bus.s_resp_ready), 0);
      if (i < 4) begin
        step();
        settle();
      end
    end
    step();
    bus.s_req_ready = 1'b1;
    settle();
    check("t3_accept_s_req_valid", 64'(bus.s_req_valid), 1);
    step();
    bus.s_req_ready  = 1'b0;
    bus.s_resp_valid = 1'b1;
    bus.s_rdata      = 32'h1234_5678;
    settle();
    check("t3_s_resp_ready", 64'(bus.s_resp_ready), 1);

    // Owner holds resp_ready low for 3 cycles; new m0 request must wait
    step();
    bus.s_resp_valid = 1'b0;
    bus.s_rdata      = '0;
    bus.m0_req_valid = 1'b1;
    bus.m0_addr      = 32'h8000_0008;
    settle();
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_m0_resp_valid", 64'(bus.m0_resp_valid), 1);
      check("t4_hold_m0_rdata",      64'(bus.m0_rdata), 64'h1234_5678);
      check("t4_hold_m0_err",        64'(bus.m0_err), 0);
      check("t4_hold_m0_req_ready",  64'(bus.m0_req_ready), 0);
      step();
      settle();
    end
    bus.m0_resp_ready = 1'b1;
    settle();
    check("t4_release_m0_resp_valid", 64'(bus.m0_resp_valid), 1);
    step();
    bus.m0_resp_ready = 1'b0;
    settle();
    check("t4_next_m0_req_ready", 64'(bus.m0_req_ready), 1);

    // Watchdog with TIMEOUT=4: slave never responds
    step();
    bus.m0_req_valid = 1'b0;
    bus.s_req_ready  = 1'b1;
    settle();
    check("t5_s_req_valid", 64'(bus.s_req_valid), 1);
    check("t5_s_addr",      64'(bus.s_addr), 64'h8000_0008);
    step();
    bus.s_req_ready = 1'b0;
    settle();
    for (int i = 0; i < 4; i++) begin
      check("t5_resp_s_resp_ready",  64'(bus.s_resp_ready), 1);
      check("t5_resp_m0_resp_valid", 64'(bus.m0_resp_valid), 0);
      step();
      settle();
    end
    bus.s_resp_valid = 1'b1;
    bus.s_rdata      = 32'hFFFF_FFFF;
    settle();
    check("t5_to_m0_resp_valid", 64'(bus.m0_resp_valid), 1);
    check("t5_to_m0_err",        64'(bus.m0_err), 1);
    check("t5_to_m0_rdata",      64'(bus.m0_rdata), 0);
    check("t5_late_s_resp_ready", 64'(bus.s_resp_ready), 0);
    step();
    bus.s_resp_valid  = 1'b0;
    bus.s_rdata       = '0;
    bus.m0_resp_ready = 1'b1;
    settle();
    check("t5_after_m0_rdata", 64'(bus.m0_rdata), 0);
    check("t5_after_m0_err",   64'(bus.m0_err), 1);
    check("t5_after_m0_resp_valid", 64'(bus.m0_resp_valid), 1);
    step();
    bus.m0_resp_ready = 1'b0;
    settle();
    check("t5_idle_m0_resp_valid", 64'(bus.m0_resp_valid), 0);

    // Reset during RESP aborts the transaction
    step();
    bus.m1_req_valid = 1'b1;
    bus.m1_addr      = 32'h8000_2000;
    settle();
    check("t6_m1_req_ready", 64'(bus.m1_req_ready), 1);
    step();
    bus.m1_req_valid = 1'b0;
    bus.s_req_ready  = 1'b1;
    settle();
    check("t6_s_req_valid", 64'(bus.s_req_valid), 1);
    step();
    bus.s_req_ready = 1'b0;
    rst = 1'b1;
    settle();
    check("t6_resp_s_resp_ready", 64'(bus.s_resp_ready), 1);
    step();
    rst = 1'b0;
    bus.s_resp_valid = 1'b1;
    bus.s_rdata      = 32'h5555_AAAA;
    settle();
    check("t6_rst_s_resp_ready",  64'(bus.s_resp_ready), 0);
    check("t6_rst_s_req_valid",   64'(bus.s_req_valid), 0);
    check("t6_rst_m1_resp_valid", 64'(bus.m1_resp_valid), 0);
    check("t6_rst_m0_resp_valid", 64'(bus.m0_resp_valid), 0);
    check("t6_rst_m1_req_ready",  64'(bus.m1_req_ready), 0);
    check("t6_rst_s_addr",        64'(bus.s_addr), 0);
    step();
    bus.s_resp_valid = 1'b0;
    bus.s_rdata      = '0;
    settle();
    check("t6_post_m1_resp_valid", 64'(bus.m1_resp_valid), 0);

    // Fresh LSU read after reset completes normally
    bus.m1_req_valid = 1'b1;
    bus.m1_addr      = 32'h8000_3000;
    settle();
    check("t7_m1_req_ready", 64'(bus.m1_req_ready), 1);
    step();
    bus.m1_req_valid = 1'b0;
    bus.s_req_ready  = 1'b1;
    settle();
    check("t7_s_addr", 64'(bus.s_addr), 64'h8000_3000);
    check("t7_s_wen",  64'(bus.s_wen), 0);
    step();
    bus.s_req_ready  = 1'b0;
    bus.s_resp_valid = 1'b1;
    bus.s_rdata      = 32'hCAFE_F00D;
    settle();
    step();
    bus.s_resp_valid  = 1'b0;
    bus.s_rdata       = '0;
    bus.m1_resp_ready = 1'b1;
    settle();
    check("t7_m1_resp_valid", 64'(bus.m1_resp_valid), 1);
    check("t7_m1_rdata",      64'(bus.m1_rdata), 64'hCAFE_F00D);
    check("t7_m1_err",        64'(bus.m1_err), 0);
    check("t7_m0_resp_valid", 64'(bus.m0_resp_valid), 0);
    step();
    bus.m1_resp_ready = 1'b0;
    settle();
    check("t7_idle_m1_resp_valid", 64'(bus.m1_resp_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
